// File: rtl/aes256_axil_slave_regs.sv
// AXI4-Lite register slave for the AES-256 IP: CTRL/STATUS/KEY/DIN/DOUT map,
// start pulse generation and capture of the core result on aes_done.
module aes256_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              aes_start,
  output logic                              aes_mode,
  output logic [255:0]                      aes_key,
  output logic [127:0]                      aes_din,
  input  logic                              aes_busy,
  input  logic                              aes_done,
  input  logic [127:0]                      aes_dout
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int KEY_BASE  = 2;
  localparam int DIN_BASE  = 10;
  localparam int DOUT_BASE = 14;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              mode_q, mode_d, done_q, done_d, err_q, err_d, start_q, start_d;
  logic [0:7][31:0]  key_q, key_d;
  logic [0:3][31:0]  din_q, din_d, dout_q, dout_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wr_fire, rd_fire;
  logic [IW-1:0]     widx, ridx;
  logic              unused_bits;

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Ready is gated by reset so no handshake can be observed while held in reset.
  assign wr_fire = s00_axi_aresetn & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
  assign rd_fire = s00_axi_aresetn & s00_axi_arvalid & ~rvalid_q;
  assign widx    = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx    = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    mode_d   = mode_q;
    done_d   = done_q;
    err_d    = err_q;
    key_d    = key_q;
    din_d    = din_q;
    dout_d   = dout_q;
    start_d  = 1'b0;
    bvalid_d = bvalid_q & ~s00_axi_bready;
    bresp_d  = bresp_q;

    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      if (widx == IW'(0)) begin
        if (aes_busy) begin
          err_d = 1'b1;
        end else begin
          bresp_d = RESP_OKAY;
          if (s00_axi_wstrb[0]) begin
            mode_d = s00_axi_wdata[1];
            if (s00_axi_wdata[0]) begin
              start_d = 1'b1;
              done_d  = 1'b0;
            end
          end
        end
      end
      if (widx == IW'(1)) begin
        bresp_d = RESP_OKAY;
        if (s00_axi_wstrb[0]) begin
          if (s00_axi_wdata[1]) done_d = 1'b0;
          if (s00_axi_wdata[2]) err_d  = 1'b0;
        end
      end
      for (int unsigned i = 0; i < 8; i++) begin
        if (widx == IW'(KEY_BASE + i)) begin
          if (aes_busy) err_d = 1'b1;
          else begin
            bresp_d  = RESP_OKAY;
            key_d[i] = strb_merge(key_q[i], s00_axi_wdata[31:0], s00_axi_wstrb[3:0]);
          end
        end
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (widx == IW'(DIN_BASE + i)) begin
          if (aes_busy) err_d = 1'b1;
          else begin
            bresp_d  = RESP_OKAY;
            din_d[i] = strb_merge(din_q[i], s00_axi_wdata[31:0], s00_axi_wstrb[3:0]);
          end
        end
        if (widx == IW'(DOUT_BASE + i)) bresp_d = RESP_OKAY;
      end
    end

    // Evaluated last so a capture beats a same-cycle W1C or START clear of DONE.
    if (aes_done) begin
      dout_d = aes_dout;
      done_d = 1'b1;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q & ~s00_axi_rready;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_SLVERR;
      rdata_d  = '0;
      if (ridx == IW'(0)) begin
        rresp_d = RESP_OKAY;
        rdata_d = {30'd0, mode_q, 1'b0};
      end
      if (ridx == IW'(1)) begin
        rresp_d = RESP_OKAY;
        rdata_d = {29'd0, err_q, done_q, aes_busy};
      end
      for (int unsigned i = 0; i < 8; i++) begin
        if (ridx == IW'(KEY_BASE + i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = key_q[i];
        end
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (ridx == IW'(DIN_BASE + i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = din_q[i];
        end
        if (ridx == IW'(DOUT_BASE + i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = dout_q[i];
        end
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      key_q    <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      key_q    <= key_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s00_axi_awready = wr_fire;
  assign s00_axi_wready  = wr_fire;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = rd_fire;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign aes_start       = start_q;
  assign aes_mode        = mode_q;
  assign aes_key         = key_q;
  assign aes_din         = din_q;

endmodule

// File: tb/tb_aes256_axil_slave_regs.sv
// Scoreboard bench for aes256_axil_slave_regs: directed plan plus random
// transactions checked against a register-map model.
module tb_aes256_axil_slave_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         aes_start, aes_mode, aes_busy, aes_done;
  logic [255:0] aes_key;
  logic [127:0] aes_din, aes_dout;

  always #5 clk = ~clk;

  aes256_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .aes_start(aes_start), .aes_mode(aes_mode), .aes_key(aes_key), .aes_din(aes_din),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_dout(aes_dout)
  );

  int n_pass = 0;
  int n_total = 0;
  int unsigned cyc = 0;
  int unsigned start_cycle = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-map model
  bit          m_mode, m_done, m_err;
  logic [31:0] m_key[8];
  logic [31:0] m_din[4];
  logic [31:0] m_dout[4];

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;
  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_mode = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_key[i] = '0;
    for (int i = 0; i < 4; i++) begin m_din[i] = '0; m_dout[i] = '0; end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    return {s[3] ? d[31:24] : o[31:24], s[2] ? d[23:16] : o[23:16],
            s[1] ? d[15:8]  : o[15:8],  s[0] ? d[7:0]   : o[7:0]};
  endfunction

  function automatic rexp_t model_read(input logic [6:0] a);
    rexp_t r;
    int w;
    w = int'(a[6:2]);
    r.resp = 2'b00;
    r.data = '0;
    if (w == 0)       r.data = {30'd0, m_mode, 1'b0};
    else if (w == 1)  r.data = {29'd0, m_err, m_done, aes_busy};
    else if (w < 10)  r.data = m_key[w-2];
    else if (w < 14)  r.data = m_din[w-10];
    else if (w < 18)  r.data = m_dout[w-14];
    else              r.resp = 2'b10;
    return r;
  endfunction

  function automatic logic [1:0] model_write(input logic [6:0] a, input logic [31:0] d,
                                             input logic [3:0] s, output bit st);
    int w;
    w = int'(a[6:2]);
    st = 0;
    if (w >= 18) return 2'b10;
    if (w >= 14) return 2'b00;
    if (w == 1) begin
      if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      return 2'b00;
    end
    if (aes_busy) begin
      m_err = 1;
      return 2'b10;
    end
    if (w == 0) begin
      if (s[0]) begin
        m_mode = d[1];
        if (d[0]) begin st = 1; m_done = 0; end
      end
    end else if (w < 10) m_key[w-2] = merge(m_key[w-2], d, s);
    else m_din[w-10] = merge(m_din[w-10], d, s);
    return 2'b00;
  endfunction

  function automatic logic [255:0] model_key();
    return {m_key[0], m_key[1], m_key[2], m_key[3], m_key[4], m_key[5], m_key[6], m_key[7]};
  endfunction

  function automatic logic [127:0] model_din();
    return {m_din[0], m_din[1], m_din[2], m_din[3]};
  endfunction

  // Monitor: pops expected responses as the DUT hands them over
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          n_total++;
          $display("FAIL bresp_unexpected: got bvalid with resp %0h, required no response", bresp);
        end else check("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          n_total++;
          $display("FAIL rdata_unexpected: got rvalid with data %0h, required no response", rdata);
        end else begin
          rexp_t e;
          e = exp_r.pop_front();
          check("rresp", rresp, e.resp);
          check("rdata", rdata, e.data);
        end
      end
      if (aes_start || cyc == start_cycle) check("aes_start", aes_start, cyc == start_cycle);
    end
  end

  // Issues any mix of write, read and done pulse; a done pulse lands in the
  // first cycle in which a handshake happens (or immediately if none pending).
  task automatic xact(input bit do_w, input logic [6:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input bit do_r, input logic [6:0] ra, input bit do_d, input logic [127:0] dv);
    bit wp, rp, dp, w_ok, r_ok, d_ok, st;
    int budget;
    rexp_t re;
    logic [1:0] br;
    wp = do_w; rp = do_r; dp = do_d; budget = 0;
    awaddr = wa; wdata = wd; wstrb = ws; awvalid = do_w; wvalid = do_w;
    araddr = ra; arvalid = do_r;
    while (wp || rp || dp) begin
      @(negedge clk);
      if (wp) check("wready_eq_awready", wready, awready);
      w_ok = wp && awready;
      r_ok = rp && arready;
      d_ok = dp && (w_ok || r_ok || (!wp && !rp));
      if (d_ok) begin aes_done = 1; aes_dout = dv; end
      if (r_ok) begin re = model_read(ra); exp_r.push_back(re); end
      if (w_ok) begin
        br = model_write(wa, wd, ws, st);
        exp_b.push_back(br);
        if (st) start_cycle = cyc + 1;
      end
      if (d_ok) begin
        m_dout[0] = dv[127:96]; m_dout[1] = dv[95:64]; m_dout[2] = dv[63:32]; m_dout[3] = dv[31:0];
        m_done = 1;
      end
      @(posedge clk); #1;
      if (w_ok) begin awvalid = 0; wvalid = 0; wp = 0; end
      if (r_ok) begin arvalid = 0; rp = 0; end
      if (d_ok) begin aes_done = 0; dp = 0; end
      budget++;
      if (budget > 50) begin
        n_total++;
        $display("FAIL xact_timeout: got no handshake in %0d cycles, required one", budget);
        awvalid = 0; wvalid = 0; arvalid = 0; aes_done = 0;
        return;
      end
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    xact(1, a, d, s, 0, '0, 0, '0);
  endtask

  task automatic rd(input logic [6:0] a);
    xact(0, '0, '0, '0, 1, a, 0, '0);
  endtask

  function automatic logic [6:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 7'($urandom);
    return {5'($urandom_range(0, 19)), 2'($urandom)};
  endfunction

  initial begin
    rst_n = 0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; wdata = '0; wstrb = '0;
    bready = 1; rready = 1; aes_busy = 0; aes_done = 0; aes_dout = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_aes_start", aes_start, 1'b0);
    check("rst_aes_key", aes_key, 256'h0);
    check("rst_aes_din", aes_din, 128'h0);
    rst_n = 1;
    @(posedge clk); #1;

    // Key load and readback
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(4 * i);
      wr(7'(8 + 4 * i), {b, b + 8'd1, b + 8'd2, b + 8'd3}, 4'hF);
    end
    for (int i = 0; i < 8; i++) rd(7'(8 + 4 * i));
    check("aes_key_plan", aes_key, 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);

    // Byte strobes
    wr(7'h28, 32'h0, 4'hF);
    wr(7'h28, 32'hAABBCCDD, 4'b0101);
    rd(7'h28);
    check("din0_strb", aes_din[127:96], 32'h00BB00DD);

    // Start pulse, done capture, W1C
    wr(7'h00, 32'h1, 4'hF);
    xact(0, '0, '0, '0, 0, '0, 1, 128'h8EA2B7CA516745BFEAFC49904B496089);
    rd(7'h38);
    rd(7'h04);
    wr(7'h04, 32'h2, 4'hF);
    rd(7'h04);
    // done coincident with DOUT read and with DONE W1C
    xact(1, 7'h04, 32'h2, 4'hF, 1, 7'h3C, 1, {4{32'hCAFEF00D}});
    rd(7'h04);
    rd(7'h3C);
    wr(7'h04, 32'h2, 4'hF);

    // Busy protection
    aes_busy = 1;
    wr(7'h14, 32'hFFFFFFFF, 4'hF);
    wr(7'h00, 32'h1, 4'hF);
    wr(7'h00, 32'h2, 4'hF);
    rd(7'h14);
    rd(7'h04);
    aes_busy = 0;
    wr(7'h04, 32'h4, 4'hF);
    check("aes_mode_busy", aes_mode, m_mode);

    // Unmapped accesses and write-response backpressure
    rd(7'h50);
    bready = 0;
    wr(7'h7C, 32'h12345678, 4'hF);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin awaddr = 7'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; end
      @(negedge clk);
      check("bvalid_hold", bvalid, 1'b1);
      check("bresp_hold", bresp, 2'b10);
      if (k >= 3) begin
        check("awready_blocked", awready, 1'b0);
        check("wready_blocked", wready, 1'b0);
      end
    end
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    bready = 1;
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int op;
      logic [31:0] d;
      logic [3:0] s;
      if ($urandom_range(0, 7) == 0) aes_busy = ~aes_busy;
      op = $urandom_range(0, 9);
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      xact(op < 6, rand_addr(), d, s, op >= 3, rand_addr(), $urandom_range(0, 7) == 0,
           {$urandom, $urandom, $urandom, $urandom});
      check("aes_key_rand", aes_key, model_key());
      check("aes_din_rand", aes_din, model_din());
      check("aes_mode_rand", aes_mode, m_mode);
    end
    aes_busy = 0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset with both responses outstanding
    bready = 0; rready = 0;
    xact(1, 7'h08, 32'h12345678, 4'hF, 1, 7'h0C, 0, '0);
    check("pre_rst_bvalid", bvalid, 1'b1);
    check("pre_rst_rvalid", rvalid, 1'b1);
    awaddr = 7'h08; awvalid = 1; wvalid = 1; araddr = 7'h08; arvalid = 1;
    #2;
    rst_n = 0;
    #1;
    check("arst_bvalid", bvalid, 1'b0);
    check("arst_rvalid", rvalid, 1'b0);
    check("arst_awready", awready, 1'b0);
    check("arst_arready", arready, 1'b0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_aes_key", aes_key, 256'h0);
    check("arst_aes_din", aes_din, 128'h0);
    check("arst_aes_mode", aes_mode, 1'b0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_b.delete();
    exp_r.delete();
    model_reset();
    bready = 1; rready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    rd(7'h08);
    rd(7'h04);
    repeat (3) @(posedge clk);
    #1;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      n_total++;
      $display("FAIL pending_responses: got %0d write and %0d read outstanding, required 0",
               exp_b.size(), exp_r.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
